// File: rtl/tern_pkg.sv
// Ternary weight encodings, FSM state type and the shared multiply / clamp-or-wrap helpers
// used by the streaming ternary matrix-vector unit.
package tern_pkg;

   localparam logic [1:0] TERN_ZERO = 2'b00;
   localparam logic [1:0] TERN_POS  = 2'b01;
   localparam logic [1:0] TERN_NEG  = 2'b11;
   localparam logic [1:0] TERN_BAD  = 2'b10;

   typedef enum logic {
      StLoad,
      StMac
   } tern_state_e;

   // Width-generic product; callers truncate to ACT_W+1 bits, which always holds the result.
   function automatic logic signed [32:0] tern_mul(input logic signed [31:0] act,
                                                   input logic [1:0]         code);
      logic signed [32:0] a;
      a = 33'(act);
      case (code)
         TERN_POS: return a;
         TERN_NEG: return -a;
         default:  return '0;
      endcase
   endfunction

   // Clamp to the signed out_w range when sat is set, otherwise keep the low out_w bits.
   function automatic logic signed [63:0] sat_clip(input logic signed [63:0] val,
                                                   input int unsigned        out_w,
                                                   input bit                 sat);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (out_w - 1));
      if (!sat) begin
         return (val <<< (64 - out_w)) >>> (64 - out_w);
      end
      if (val > hi) begin
         return hi;
      end
      if (val < lo) begin
         return lo;
      end
      return val;
   endfunction

endpackage

// File: rtl/tern_lane_sum.sv
// Combinational LANES-way ternary multiply followed by a balanced adder tree; also reports
// whether any lane carried the illegal weight code.
module tern_lane_sum
   import tern_pkg::*;
#(
   parameter int unsigned ACT_W = 8,
   parameter int unsigned LANES = 16
) (
   input  logic [LANES*ACT_W-1:0]                i_act,
   input  logic [LANES*2-1:0]                    i_codes,
   output logic signed [ACT_W+$clog2(LANES):0]   o_sum,
   output logic                                  o_illegal
);

   localparam int unsigned SUM_W = ACT_W + $clog2(LANES) + 1;
   localparam int unsigned NODES = 2 * LANES - 1;

   // Heap-ordered tree: leaves at [LANES-1 +: LANES], node n sums children 2n+1 and 2n+2.
   logic signed [SUM_W-1:0] w_node [NODES];

   always_comb begin
      o_illegal = 1'b0;
      for (int n = 0; n < int'(NODES); n++) begin
         w_node[n] = '0;
      end
      for (int i = 0; i < int'(LANES); i++) begin
         w_node[int'(LANES) - 1 + i] =
            SUM_W'(tern_mul(32'(signed'(i_act[i*ACT_W +: ACT_W])), i_codes[2*i +: 2]));
         if (i_codes[2*i +: 2] == TERN_BAD) begin
            o_illegal = 1'b1;
         end
      end
      for (int n = int'(LANES) - 2; n >= 0; n--) begin
         w_node[n] = w_node[2*n + 1] + w_node[2*n + 2];
      end
      o_sum = w_node[0];
   end

endmodule

// File: rtl/tern_matvec_stream.sv
// Streaming ternary matrix-vector unit: buffers one activation vector, then accumulates one
// LANES-wide weight beat per cycle into a row sum and emits each row through a one-entry output.
module tern_matvec_stream
   import tern_pkg::*;
#(
   parameter int unsigned ACT_W   = 8,
   parameter int unsigned VEC_LEN = 4096,
   parameter int unsigned ROWS    = 4096,
   parameter int unsigned LANES   = 16,
   parameter int unsigned ACC_W   = ACT_W + $clog2(VEC_LEN),
   parameter int unsigned OUT_W   = ACC_W,
   parameter bit          SAT     = 1'b1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   act_valid,
   output logic                   act_ready,
   input  logic [LANES*ACT_W-1:0] act_data,
   input  logic                   w_valid,
   output logic                   w_ready,
   input  logic [LANES*2-1:0]     w_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [OUT_W-1:0]       out_data,
   output logic                   out_last,
   output logic                   err
);

   localparam int unsigned CHUNKS = VEC_LEN / LANES;
   localparam int unsigned COL_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
   localparam int unsigned ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int unsigned SUM_W  = ACT_W + $clog2(LANES) + 1;
   // One guard bit: a full row of -2^(ACT_W-1) * -1 reaches exactly +2^(ACC_W-1).
   localparam int unsigned ACC_IW = ACC_W + 1;

   tern_state_e              r_state;
   logic [COL_W-1:0]         r_col;
   logic [ROW_W-1:0]         r_row;
   logic signed [ACC_IW-1:0] r_acc;
   logic                     r_out_valid;
   logic [OUT_W-1:0]         r_out_data;
   logic                     r_out_last;
   logic                     r_err;
   logic [LANES*ACT_W-1:0]   r_act_buf [CHUNKS];

   logic                     w_act_hs;
   logic                     w_wgt_hs;
   logic                     w_last_col;
   logic                     w_last_row;
   logic                     w_illegal;
   logic signed [SUM_W-1:0]  w_lane_sum;
   logic signed [ACC_IW-1:0] w_acc_next;

   assign act_ready  = (r_state == StLoad);
   assign w_ready    = (r_state == StMac) && (!r_out_valid || out_ready);
   assign w_act_hs   = act_valid && act_ready;
   assign w_wgt_hs   = w_valid && w_ready;
   assign w_last_col = (r_col == COL_W'(CHUNKS - 1));
   assign w_last_row = (r_row == ROW_W'(ROWS - 1));
   assign w_acc_next = r_acc + ACC_IW'(w_lane_sum);

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_last  = r_out_last;
   assign err       = r_err;

   tern_lane_sum #(
      .ACT_W (ACT_W),
      .LANES (LANES)
   ) u_lane_sum (
      .i_act     (r_act_buf[r_col]),
      .i_codes   (w_data),
      .o_sum     (w_lane_sum),
      .o_illegal (w_illegal)
   );

   // Payload storage only; validity is tracked by the FSM, so no reset is needed.
   always_ff @(posedge clk) begin
      if (w_act_hs) begin
         r_act_buf[r_col] <= act_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= StLoad;
         r_col       <= '0;
         r_row       <= '0;
         r_acc       <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_last  <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
         end
         case (r_state)
            StLoad: begin
               if (w_act_hs) begin
                  if (w_last_col) begin
                     r_col   <= '0;
                     r_state <= StMac;
                  end else begin
                     r_col <= r_col + 1'b1;
                  end
               end
            end
            StMac: begin
               if (w_wgt_hs) begin
                  if (w_illegal) begin
                     r_err <= 1'b1;
                  end
                  if (w_last_col) begin
                     r_col       <= '0;
                     r_acc       <= '0;
                     r_out_data  <= OUT_W'(sat_clip(64'(w_acc_next), OUT_W, SAT));
                     r_out_valid <= 1'b1;
                     r_out_last  <= w_last_row;
                     if (w_last_row) begin
                        r_row   <= '0;
                        r_state <= StLoad;
                     end else begin
                        r_row <= r_row + 1'b1;
                     end
                  end else begin
                     r_col <= r_col + 1'b1;
                     r_acc <= w_acc_next;
                  end
               end
            end
            default: r_state <= StLoad;
         endcase
      end
   end

endmodule
